router_input_channel: RTL and testbench

- Per-port ingress stage of the mesh router. It sits directly upstream of the output-channel stage.
- Accepts flits from a neighbour link or the local PE into two polarity-alternated single-entry virtual-channel buffers, and performs XY route computation with hop-count decrement at write time.
- Presents the routed flit and its target port to the crossbar/output channel and holds it until granted.
- An all-zero flit means "empty" throughout the router and is never a legal flit.

---
 rtl/router_input_channel.sv | 65 ++++++
 tb/tb_router_input_channel.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/router_input_channel.sv
// router_input_channel: two-VC ingress buffer with XY route/hop decrement at write; ports clk/reset, polarity, si/di/ri link side, out_valid/out_port/out_data/out_grant crossbar side, err sticky, flit_cnt accepted count
module router_input_channel #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 polarity,
  input  logic                 si,
  input  logic [63:0]          di,
  output logic                 ri,
  output logic                 out_valid,
  output logic [2:0]           out_port,
  output logic [63:0]          out_data,
  input  logic                 out_grant,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] flit_cnt
);
  logic        valid [2];
  logic [63:0] data [2];
  logic [2:0]  port [2];
  logic        w, r, acc, viol, consume;
  logic [3:0]  hx, hy;
  logic [2:0]  rport;
  logic [63:0] rdata;
  always_comb begin
    w = ~polarity;
    r = polarity;
    hx = di[55:52];
    hy = di[51:48];
    ri = !reset && !valid[w];
    acc = si && ri && di != '0 && di[63] == w;
    viol = si && (!ri || di == '0 || di[63] != w);
    consume = valid[r] && out_grant;
    rport = hx != '0 ? {2'b00, di[62]} : hy != '0 ? {2'b01, di[61]} : 3'd4;
    rdata = hx != '0 ? {di[63:56], hx - 4'd1, di[51:0]} :
            hy != '0 ? {di[63:52], hy - 4'd1, di[47:0]} : di;
    out_valid = valid[r];
    out_data = data[r];
    out_port = port[r];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        valid[i] <= 1'b0;
        data[i] <= '0;
        port[i] <= '0;
      end
      err <= 1'b0;
      flit_cnt <= '0;
    end else begin
      if (consume) begin
        valid[r] <= 1'b0;
        data[r] <= '0;
        port[r] <= '0;
      end
      if (acc) begin
        valid[w] <= 1'b1;
        data[w] <= rdata;
        port[w] <= rport;
        flit_cnt <= flit_cnt + CNT_WIDTH'(1);
      end
      if (viol) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_router_input_channel.sv
// tb_router_input_channel: directed vectors with hand-computed expectations for router_input_channel
module tb_router_input_channel;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        polarity = 1'b1;
  logic        si = 1'b0;
  logic [63:0] di = '0;
  logic        ri;
  logic        out_valid;
  logic [2:0]  out_port;
  logic [63:0] out_data;
  logic        out_grant = 1'b0;
  logic        err;
  logic [15:0] flit_cnt;
  int total = 0;
  int bad = 0;
  router_input_channel #(.CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .polarity(polarity), .si(si), .di(di), .ri(ri),
    .out_valid(out_valid), .out_port(out_port), .out_data(out_data),
    .out_grant(out_grant), .err(err), .flit_cnt(flit_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic apply(input logic p, input logic s, input logic [63:0] d, input logic g);
    polarity = p;
    si = s;
    di = d;
    out_grant = g;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    apply(1'b1, 1'b0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic out_is(input string tag, input logic v, input logic [2:0] p, input logic [63:0] d);
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    chk({tag, "_port"}, 64'(out_port), 64'(p));
    chk({tag, "_data"}, out_data, d);
  endtask
  initial begin
    do_reset();
    chk("rst_ri_held", 64'(ri), 64'd0);
    apply(1'b0, 1'b0, '0, 1'b0);
    tick();
    apply(1'b1, 1'b0, '0, 1'b0);
    tick();
    chk("idle_ri", 64'(ri), 64'd1);
    out_is("idle", 1'b0, 3'd0, 64'd0);
    chk("idle_err", 64'(err), 64'd0);
    chk("idle_cnt", 64'(flit_cnt), 64'd0);
    apply(1'b1, 1'b1, 64'h0003_0000_0000_00AA, 1'b0);
    tick();
    chk("full_ri", 64'(ri), 64'd0);
    chk("hidden", 64'(out_valid), 64'd0);
    apply(1'b0, 1'b0, '0, 1'b0);
    out_is("ynorth", 1'b1, 3'd2, 64'h0002_0000_0000_00AA);
    chk("cnt1", 64'(flit_cnt), 64'd1);
    apply(1'b0, 1'b0, '0, 1'b1);
    tick();
    chk("consumed", 64'(out_valid), 64'd0);
    apply(1'b1, 1'b1, 64'h4021_0000_0000_1234, 1'b0);
    tick();
    apply(1'b0, 1'b1, 64'h8000_0000_0000_0055, 1'b0);
    out_is("xwest", 1'b1, 3'd1, 64'h4011_0000_0000_1234);
    tick();
    apply(1'b1, 1'b0, '0, 1'b1);
    out_is("local", 1'b1, 3'd4, 64'h8000_0000_0000_0055);
    tick();
    apply(1'b0, 1'b0, '0, 1'b1);
    out_is("xwest_kept", 1'b1, 3'd1, 64'h4011_0000_0000_1234);
    tick();
    chk("cnt3", 64'(flit_cnt), 64'd3);
    apply(1'b1, 1'b1, 64'h0010_0000_0000_0001, 1'b0);
    tick();
    apply(1'b0, 1'b0, '0, 1'b0);
    tick();
    apply(1'b1, 1'b1, 64'h0020_0000_0000_0002, 1'b0);
    chk("blk_ri", 64'(ri), 64'd0);
    tick();
    chk("blk_err", 64'(err), 64'd1);
    chk("blk_cnt", 64'(flit_cnt), 64'd4);
    apply(1'b0, 1'b0, '0, 1'b0);
    out_is("blk_hold", 1'b1, 3'd0, 64'h0000_0000_0000_0001);
    apply(1'b0, 1'b0, '0, 1'b1);
    tick();
    chk("blk_drain", 64'(out_valid), 64'd0);
    apply(1'b1, 1'b0, '0, 1'b0);
    chk("blk_dropped", 64'(out_valid), 64'd0);
    do_reset();
    chk("rst_err", 64'(err), 64'd0);
    apply(1'b1, 1'b1, 64'h0000_0000_0000_00A0, 1'b0);
    tick();
    apply(1'b0, 1'b1, 64'h8001_0000_0000_00B0, 1'b1);
    out_is("sA", 1'b1, 3'd4, 64'h0000_0000_0000_00A0);
    tick();
    chk("sim_cons", 64'(out_valid), 64'd0);
    chk("sim_ri", 64'(ri), 64'd0);
    apply(1'b1, 1'b1, 64'h2002_0000_0000_00C0, 1'b1);
    out_is("sB", 1'b1, 3'd2, 64'h8000_0000_0000_00B0);
    tick();
    apply(1'b0, 1'b1, 64'h80F0_0000_0000_00D0, 1'b1);
    out_is("sC", 1'b1, 3'd3, 64'h2001_0000_0000_00C0);
    tick();
    apply(1'b1, 1'b0, '0, 1'b1);
    out_is("sD", 1'b1, 3'd0, 64'h80E0_0000_0000_00D0);
    tick();
    apply(1'b0, 1'b0, '0, 1'b1);
    chk("s_empty", 64'(out_valid), 64'd0);
    chk("s_cnt", 64'(flit_cnt), 64'd4);
    chk("s_err", 64'(err), 64'd0);
    do_reset();
    apply(1'b1, 1'b1, 64'h8000_0000_0000_0011, 1'b0);
    tick();
    chk("vc_err", 64'(err), 64'd1);
    chk("vc_cnt", 64'(flit_cnt), 64'd0);
    chk("vc_ri", 64'(ri), 64'd1);
    apply(1'b0, 1'b0, '0, 1'b0);
    chk("vc_noacc", 64'(out_valid), 64'd0);
    do_reset();
    apply(1'b1, 1'b1, 64'd0, 1'b0);
    tick();
    chk("zero_err", 64'(err), 64'd1);
    chk("zero_cnt", 64'(flit_cnt), 64'd0);
    do_reset();
    apply(1'b1, 1'b1, 64'h0000_0000_0000_0077, 1'b0);
    tick();
    apply(1'b0, 1'b1, 64'h8000_0000_0000_0088, 1'b0);
    tick();
    reset = 1'b1;
    apply(1'b1, 1'b0, '0, 1'b0);
    tick();
    out_is("mid_rst1", 1'b0, 3'd0, 64'd0);
    chk("mid_ri", 64'(ri), 64'd0);
    apply(1'b0, 1'b0, '0, 1'b0);
    out_is("mid_rst0", 1'b0, 3'd0, 64'd0);
    reset = 1'b0;
    #1;
    chk("mid_cnt", 64'(flit_cnt), 64'd0);
    chk("mid_ri_rel", 64'(ri), 64'd1);
    apply(1'b1, 1'b0, '0, 1'b0);
    out_is("mid_vc1", 1'b0, 3'd0, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
